// File: rtl/ppu_pack_if.sv
// Stream bundle for ppu_pack: quantized bytes in, packed words out.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface ppu_pack_if #(
    parameter int OUT_BYTES = 4
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   out_valid;
    logic [8*OUT_BYTES-1:0] out_data;
    logic [OUT_BYTES-1:0]   out_strb;
    logic                   out_last;
    logic                   out_ready;
    logic [15:0]            word_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_strb, out_last, word_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_strb, out_last, word_cnt
    );
endinterface

// File: rtl/ppu_pack.sv
// Packs uint8 bytes into little-endian OUT_BYTES-wide words; a tile's last byte
// closes a short word with a partial strobe. One-deep output register, no bubbles.
module ppu_pack #(
    parameter int OUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    ppu_pack_if.slave  bus
);
    localparam int W      = 8 * OUT_BYTES;
    localparam int FILL_W = $clog2(OUT_BYTES);
    localparam logic [FILL_W-1:0] LAST_LANE = FILL_W'(OUT_BYTES - 1);

    if (!(OUT_BYTES == 2 || OUT_BYTES == 4 || OUT_BYTES == 8)) begin : g_bad_out_bytes
        $error("ppu_pack: OUT_BYTES must be 2, 4 or 8");
    end

    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [W-1:0]         stage_q, stage_d;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic [OUT_BYTES-1:0] out_strb_q, out_strb_d;
    logic                 out_last_q, out_last_d;
    logic [15:0]          word_cnt_q, word_cnt_d;

    logic                 in_ready;
    logic                 accept;
    logic                 handoff;
    logic                 complete;
    logic [W-1:0]         merged;
    logic [OUT_BYTES-1:0] strb_fill;

    // The output slot is free when empty or being drained this very edge.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign handoff  = out_valid_q && bus.out_ready;
    assign complete = accept && ((fill_q == LAST_LANE) || bus.in_last);

    // Staging lanes above the fill point are always zero, so merged is the
    // finished word with its unused upper lanes already cleared.
    always_comb begin
        merged    = stage_q;
        strb_fill = '0;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (fill_q == FILL_W'(k)) begin
                merged[8*k +: 8] = bus.in_data;
            end
            if (FILL_W'(k) <= fill_q) begin
                strb_fill[k] = 1'b1;
            end
        end
    end

    always_comb begin
        fill_d      = fill_q;
        stage_d     = stage_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;

        if (handoff) begin
            out_valid_d = 1'b0;
            word_cnt_d  = word_cnt_q + 16'd1;
        end

        // A completion in the same edge as a handoff overrides the drop of out_valid.
        if (accept) begin
            if (complete) begin
                fill_d      = '0;
                stage_d     = '0;
                out_valid_d = 1'b1;
                out_data_d  = merged;
                out_strb_d  = strb_fill;
                out_last_d  = bus.in_last;
            end else begin
                fill_d  = fill_q + FILL_W'(1);
                stage_d = merged;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q      <= '0;
            stage_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            fill_q      <= fill_d;
            stage_q     <= stage_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_strb  = out_strb_q;
    assign bus.out_last  = out_last_q;
    assign bus.word_cnt  = word_cnt_q;

    a_strb_nonzero : assert property (@(posedge clk) disable iff (rst)
        out_valid_q |-> (out_strb_q != '0));

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_strb_q) && $stable(out_last_q)));
endmodule
